// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker: exhaustive sweep of every N_IN-bit vector onto two
// combinational implementations, counting mismatching vectors (saturating)
// and latching the first failing vector.
// Optional build macro: STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module equiv_sweep_checker #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N_OUT-1:0] f_a,
   input  logic [N_OUT-1:0] f_b,
   output logic [N_IN-1:0]  stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [N_IN-1:0]  first_fail_vec
);

   localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [WAIT_W-1:0] wait_cnt;
   logic              fail_seen;
   logic              mismatch;
   logic              last_vec;
   logic              stop_now;

   assign mismatch = |(f_a ^ f_b);
   assign last_vec = (stim == {N_IN{1'b1}});
`ifdef STOP_ON_FAIL_EN
   assign stop_now = mismatch;
`else
   assign stop_now = 1'b0;
`endif

   // Next-state selection for the sweep sequencer.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_SETTLE;
         S_SETTLE:       if (wait_cnt == '0) state_nx = S_COMPARE;
         S_COMPARE:      state_nx = (last_vec || stop_now) ? S_DONE : S_SETTLE;
         default:        state_nx = S_IDLE;
      endcase
   end

   // State register plus all registered outputs and sweep bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         stim           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         mismatch_count <= '0;
         first_fail_vec <= '0;
         fail_seen      <= 1'b0;
         wait_cnt       <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  stim           <= '0;
                  mismatch_count <= '0;
                  first_fail_vec <= '0;
                  fail_seen      <= 1'b0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  wait_cnt       <= WAIT_LOAD;
               end else if (state == S_DONE) begin
                  // Results are final here; publish them one cycle after entry.
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (mismatch_count == '0);
               end
            end
            S_SETTLE: begin
               if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            end
            S_COMPARE: begin
               if (mismatch) begin
                  if (mismatch_count != {CNT_W{1'b1}})
                     mismatch_count <= mismatch_count + 1'b1;
                  if (!fail_seen) begin
                     first_fail_vec <= stim;
                     fail_seen      <= 1'b1;
                  end
               end
               // The last vector holds stim so it never wraps back to zero.
               if (!(last_vec || stop_now)) begin
                  stim     <= stim + 1'b1;
                  wait_cnt <= WAIT_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Bench for equiv_sweep_checker: two instances with different parameters,
// random truth tables, scoreboard queues filled at start and drained by a
// monitor on each rising done.
module tb_equiv_sweep_checker;

   typedef struct {
      int count;
      int ff;
      int pass;
      int fin;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   int   cyc = 0;
   int   t0 = 0;
   int   checks = 0;
   int   errors = 0;

   logic [1:0] tab_a0 [16];
   logic [1:0] tab_b0 [16];
   logic [1:0] tab_a1 [16];
   logic [1:0] tab_b1 [16];

   logic [0:0] f_a0, f_b0;
   logic [1:0] f_a1, f_b1;
   logic [2:0] stim0, ff0;
   logic [3:0] stim1, ff1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic       busy0, done0, pass0, busy1, done1, pass1;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign f_a0 = tab_a0[{1'b0, stim0}][0];
   assign f_b0 = tab_b0[{1'b0, stim0}][0];
   assign f_a1 = tab_a1[stim1];
   assign f_b1 = tab_b1[stim1];

   equiv_sweep_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .f_a(f_a0), .f_b(f_b0),
      .stim(stim0), .busy(busy0), .done(done0), .pass(pass0),
      .mismatch_count(cnt0), .first_fail_vec(ff0));

   equiv_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(2), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .f_a(f_a1), .f_b(f_b1),
      .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
      .mismatch_count(cnt1), .first_fail_vec(ff1));

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: walk the truth tables in vector order.
   function automatic exp_t model(input logic [1:0] a [16], input logic [1:0] b [16],
                                  input int n_in, input int settle, input int cmax);
      exp_t e;
      bit   seen = 0;
      e.count = 0; e.ff = 0; e.pass = 1;
      e.fin = (1 << n_in) - 1;
      e.lat = (1 << n_in) * (settle + 1) + 1;
      for (int v = 0; v < (1 << n_in); v++) begin
         if (a[v] != b[v]) begin
            if (!seen) begin e.ff = v; seen = 1; end
            if (e.count < cmax) e.count++;
            e.pass = 0;
`ifdef STOP_ON_FAIL_EN
            e.fin = v;
            e.lat = (settle + 1) * (v + 1) + 1;
            break;
`endif
         end
      end
      return e;
   endfunction

   // Monitor for dut0.
   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done0 && !prev) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
            else begin
               e = q0.pop_front();
               chk("dut0_count", int'(cnt0), e.count);
               chk("dut0_first_fail", int'(ff0), e.ff);
               chk("dut0_pass", int'(pass0), e.pass);
               chk("dut0_final_stim", int'(stim0), e.fin);
               chk("dut0_busy_at_done", int'(busy0), 0);
               chk("dut0_latency", cyc - 1 - t0, e.lat);
            end
         end
         prev = done0;
      end
   end

   // Monitor for dut1.
   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done1 && !prev) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else begin
               e = q1.pop_front();
               chk("dut1_count", int'(cnt1), e.count);
               chk("dut1_first_fail", int'(ff1), e.ff);
               chk("dut1_pass", int'(pass1), e.pass);
               chk("dut1_final_stim", int'(stim1), e.fin);
               chk("dut1_latency", cyc - 1 - t0, e.lat);
            end
         end
         prev = done1;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_stim0"}, int'(stim0), 0);
      chk({tag, "_busy0"}, int'(busy0), 0);
      chk({tag, "_done0"}, int'(done0), 0);
      chk({tag, "_pass0"}, int'(pass0), 0);
      chk({tag, "_cnt0"}, int'(cnt0), 0);
      chk({tag, "_ff0"}, int'(ff0), 0);
      chk({tag, "_stim1"}, int'(stim1), 0);
      chk({tag, "_busy1"}, int'(busy1), 0);
      chk({tag, "_done1"}, int'(done1), 0);
      chk({tag, "_cnt1"}, int'(cnt1), 0);
   endtask

   task automatic rand_tab1(input int density);
      for (int v = 0; v < 16; v++) begin
         tab_a1[v] = 2'($urandom_range(0, 3));
         tab_b1[v] = ($urandom_range(0, density) == 0) ? 2'($urandom_range(0, 3)) : tab_a1[v];
      end
   endtask

   task automatic rand_tab0(input int density);
      for (int v = 0; v < 16; v++) begin
         tab_a0[v] = 2'($urandom_range(0, 1));
         tab_b0[v] = ($urandom_range(0, density) == 0) ? ~tab_a0[v] & 2'b01 : tab_a0[v];
      end
   endtask

   // One sweep on both instances; restart_at/reset_at are cycle offsets (0 = none).
   task automatic run_sweep(input int restart_at, input int reset_at);
      int n;
      q0.push_back(model(tab_a0, tab_b0, 3, 1, 255));
      q1.push_back(model(tab_a1, tab_b1, 4, 2, 3));
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy0", int'(busy0), 1);
      chk("start_done0", int'(done0), 0);
      chk("start_stim1", int'(stim1), 0);
      if (restart_at > 0) begin
         while (cyc < t0 + restart_at) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (reset_at > 0) begin
         while (cyc < t0 + reset_at) @(negedge clk);
         chk("pre_reset_busy0", int'(busy0), 1);
         rst_n = 1'b0;
         #1;
         check_zero("abort");
         q0.delete();
         q1.delete();
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         chk("sweep_timeout", q0.size() + q1.size(), 0);
         q0.delete();
         q1.delete();
      end
      repeat (2) @(negedge clk);
      chk("done_hold0", int'(done0), 1);
      chk("done_hold1", int'(done1), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      for (int v = 0; v < 16; v++) begin
         tab_a0[v] = '0; tab_b0[v] = '0; tab_a1[v] = '0; tab_b1[v] = '0;
      end
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Identical a&b|c implementations.
      for (int v = 0; v < 16; v++) begin
         tab_a0[v] = 2'((((v >> 2) & (v >> 1)) | v) & 1);
         tab_b0[v] = tab_a0[v];
      end
      rand_tab1(8);
      run_sweep(0, 0);

      // Single difference at vector 5.
      tab_b0[5] = ~tab_a0[5] & 2'b01;
      rand_tab1(3);
      run_sweep(0, 0);

      // Complement on dut1 saturates its 2-bit counter.
      for (int v = 0; v < 16; v++) tab_b1[v] = ~tab_a1[v];
      run_sweep(0, 0);

      // Start pulsed mid-sweep is ignored.
      run_sweep(6, 0);

      // Reset mid-sweep, then a fresh full sweep.
      run_sweep(0, 9);
      run_sweep(0, 0);

      // Mismatches at vectors 2 and 6.
      for (int v = 0; v < 16; v++) tab_b0[v] = tab_a0[v];
      tab_b0[2] = ~tab_a0[2] & 2'b01;
      tab_b0[6] = ~tab_a0[6] & 2'b01;
      rand_tab1(20);
      run_sweep(0, 0);

      // Randomized sweeps.
      for (int i = 0; i < 12; i++) begin
         rand_tab0($urandom_range(0, 6));
         rand_tab1($urandom_range(0, 10));
         run_sweep(($urandom_range(0, 3) == 0) ? 5 : 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
